// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch slice.
package rv_fetch_pkg;
    localparam int              INSTR_W = 32;
    localparam int              XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem request/response, redirect input and decode-facing output.
interface fetch_unit_if;
    import rv_fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_base;
    logic [XLEN-1:0] redirect_imm;
    logic            instr_valid;
    logic            instr_ready;
    logic [INSTR_W-1:0] instr_out;
    logic [XLEN-1:0] instr_pc;
    logic            fetch_misalign;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc, fetch_misalign,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_base, redirect_imm, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc, fetch_misalign,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_base, redirect_imm, instr_ready
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Small power-of-2 FIFO of fetched words; head is read straight from registered storage.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  fetch_entry_t            i_push_data,
    input  logic                    i_pop,
    output fetch_entry_t            o_head,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // A push into a full buffer is only taken when the head leaves in the same cycle.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FULL) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC and credit control, redirect with stale-word dropping, buffered output to decode.
module fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW+1:0] DEPTH_L = (CW+2)'(FIFO_DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic            r_misalign;

    logic [CW-1:0]   w_fifo_count;
    logic [CW+1:0]   w_credit_used;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_keep;
    logic            w_rsp_drop;
    logic            w_instr_valid;
    logic            w_pop;
    logic [XLEN-1:0] w_target_raw;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // Every word holds one credit from request accept until it is popped or dropped.
    assign w_credit_used = {2'b00, r_outstanding} + {2'b00, w_fifo_count} + {2'b00, r_drop_cnt};
    assign w_req_valid   = !rst && (w_credit_used < DEPTH_L) && !bus.redirect_valid;
    assign w_req_fire    = w_req_valid && bus.imem_req_ready;
    assign w_rsp_drop    = bus.imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_keep    = bus.imem_rsp_valid && (r_drop_cnt == '0);
    assign w_instr_valid = (w_fifo_count != '0);
    assign w_pop         = w_instr_valid && bus.instr_ready;
    assign w_target_raw  = bus.redirect_base + bus.redirect_imm;
    assign w_push_entry  = '{instr: bus.imem_rsp_data, pc: r_rsp_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_misalign    <= 1'b0;
        end else if (bus.redirect_valid) begin
            // In-flight words become stale; one may be retired by a response this very cycle.
            r_fetch_pc    <= word_align(w_target_raw);
            r_rsp_pc      <= word_align(w_target_raw);
            r_outstanding <= '0;
            r_drop_cnt    <= r_drop_cnt + r_outstanding - CW'(bus.imem_rsp_valid);
            if (w_target_raw[1]) r_misalign <= 1'b1;
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + PC_STEP;
            if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_keep);
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (bus.redirect_valid),
        .i_push      (w_rsp_keep),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.instr_valid    = w_instr_valid;
    assign bus.instr_out      = w_head.instr;
    assign bus.instr_pc       = w_head.pc;
    assign bus.fetch_misalign = r_misalign;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory, epoch-tagged stream reference model, vector table and random traffic.
module tb_fetch_unit;
    import rv_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory requests carry the epoch they were issued in; a redirect starts a new epoch.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          epoch;
        int          rdy;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] imm;
        int          lat;
        logic [31:0] exp_addr;
        logic        exp_mis;
    } rvec_t;

    mreq_t       memq[$];
    word_t       bufq[$];
    int          epoch, cyc, mem_lat;
    int          n_checks, n_err;
    logic [31:0] m_addr;
    logic        m_mis;

    logic        s_reqv, s_ivalid, s_mis;
    logic [31:0] s_reqaddr, s_ipc, s_iout;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare 1ns later, advance the model at posedge.
    task automatic tick(input logic r, input logic rv, input logic [31:0] rb, input logic [31:0] ri,
                        input logic irdy, input logic mrdy);
        logic        rsp, ev, fire, pop;
        logic [31:0] raw;
        mreq_t       e;
        word_t       w;
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_base  = rb;
        bus.redirect_imm   = ri;
        bus.instr_ready    = irdy;
        bus.imem_req_ready = mrdy;
        rsp = !r && (memq.size() > 0) && (memq[0].rdy <= cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(memq[0].addr) : 32'hDEAD_BEEF;
        #1;
        s_reqv    = bus.imem_req_valid;
        s_reqaddr = bus.imem_req_addr;
        s_ivalid  = bus.instr_valid;
        s_ipc     = bus.instr_pc;
        s_iout    = bus.instr_out;
        s_mis     = bus.fetch_misalign;
        if (r) begin
            chk("req_valid_in_rst", 32'(s_reqv), 32'(0));
        end else begin
            ev = !rv && ((memq.size() + bufq.size()) < DEPTH);
            chk("req_valid", 32'(s_reqv), 32'(ev));
            if (ev) chk("req_addr", s_reqaddr, m_addr);
            chk("instr_valid", 32'(s_ivalid), 32'(bufq.size() != 0));
            if (bufq.size() != 0) begin
                chk("instr_pc", s_ipc, bufq[0].pc);
                chk("instr_out", s_iout, bufq[0].instr);
            end
            chk("fetch_misalign", 32'(s_mis), 32'(m_mis));
        end
        fire = s_reqv && mrdy;
        pop  = s_ivalid && irdy;
        @(posedge clk);
        if (r) begin
            memq.delete();
            bufq.delete();
            m_addr = RESET_PC;
            m_mis  = 1'b0;
            epoch++;
        end else begin
            if (!rv && pop && bufq.size() > 0) w = bufq.pop_front();
            if (rsp) begin
                e = memq.pop_front();
                if (!rv && e.epoch == epoch) bufq.push_back('{pc: e.pc, instr: mem_word(e.pc)});
            end
            if (rv) begin
                raw = rb + ri;
                bufq.delete();
                epoch++;
                m_addr = raw & 32'hFFFF_FFFC;
                if (raw[1]) m_mis = 1'b1;
            end else if (fire) begin
                memq.push_back('{addr: s_reqaddr, pc: m_addr, epoch: epoch, rdy: cyc + mem_lat});
                m_addr = m_addr + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input logic irdy);
        tick(1'b0, 1'b0, 32'h0, 32'h0, irdy, 1'b1);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!s_ivalid && n < 40) begin
            run(1'b1);
            n++;
        end
        if (!s_ivalid) chk(name, 32'(s_ivalid), 32'(1));
    endtask

    rvec_t       vt[5];
    logic [31:0] pcs[$];
    logic [31:0] last_pc;
    int          first;

    initial begin
        n_checks = 0; n_err = 0; cyc = 0; epoch = 0; mem_lat = 1;
        m_addr = RESET_PC; m_mis = 1'b0;
        rst = 1'b1;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
        bus.redirect_valid = 1'b0; bus.redirect_base = '0; bus.redirect_imm = '0;
        bus.instr_ready = 1'b0;
        @(negedge clk);

        // reset values
        do_reset();
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'(0));
        chk("rst_instr_out", bus.instr_out, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_misalign", 32'(bus.fetch_misalign), 32'(0));
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'(0));

        // straight-line fetch, 1-cycle memory; first word visible in the third cycle after reset
        mem_lat = 1; first = -1; pcs.delete();
        for (int c = 0; c < 12; c++) begin
            run(1'b1);
            if (s_ivalid) begin
                if (first < 0) first = c;
                pcs.push_back(s_ipc);
            end
        end
        chk("first_valid_cycle", 32'(first), 32'(2));
        if (pcs.size() >= 4) begin
            chk("seq_pc0", pcs[0], 32'h0);
            chk("seq_pc1", pcs[1], 32'h4);
            chk("seq_pc2", pcs[2], 32'h8);
            chk("seq_pc3", pcs[3], 32'hC);
        end else chk("seq_count", 32'(pcs.size()), 32'(4));
        last_pc = (pcs.size() > 0) ? pcs[pcs.size()-1] : 32'h0;

        // decode stall: buffer fills, requests stop, nothing lost
        for (int c = 0; c < 10; c++) run(1'b0);
        chk("stall_valid", 32'(s_ivalid), 32'(1));
        chk("stall_req_valid", 32'(s_reqv), 32'(0));
        pcs.delete();
        for (int c = 0; c < 10 && pcs.size() < 2; c++) begin
            run(1'b1);
            if (s_ivalid) pcs.push_back(s_ipc);
        end
        if (pcs.size() == 2) begin
            chk("release_pc0", pcs[0], last_pc + 32'd4);
            chk("release_pc1", pcs[1], last_pc + 32'd8);
        end else chk("release_count", 32'(pcs.size()), 32'(2));

        // redirect vectors: two warm cycles, redirect, then target address and first word
        vt[0] = '{base: 32'h0000_0100, imm: 32'hFFFF_FFF0, lat: 3, exp_addr: 32'h0000_00F0, exp_mis: 1'b0};
        vt[1] = '{base: 32'h0000_0200, imm: 32'h0000_0006, lat: 1, exp_addr: 32'h0000_0204, exp_mis: 1'b1};
        vt[2] = '{base: 32'hFFFF_FFFC, imm: 32'h0000_0008, lat: 2, exp_addr: 32'h0000_0004, exp_mis: 1'b0};
        vt[3] = '{base: 32'h0000_0000, imm: 32'hFFFF_FFFE, lat: 3, exp_addr: 32'hFFFF_FFFC, exp_mis: 1'b1};
        vt[4] = '{base: 32'h0000_1000, imm: 32'h0000_0000, lat: 1, exp_addr: 32'h0000_1000, exp_mis: 1'b0};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            mem_lat = vt[i].lat;
            run(1'b1);
            run(1'b1);
            tick(1'b0, 1'b1, vt[i].base, vt[i].imm, 1'b1, 1'b1);
            run(1'b1);
            chk("redir_addr", s_reqaddr, vt[i].exp_addr);
            chk("redir_misalign", 32'(s_mis), 32'(vt[i].exp_mis));
            wait_valid("redir_wait_timeout");
            chk("redir_first_pc", s_ipc, vt[i].exp_addr);
            for (int c = 0; c < 6; c++) run(1'b1);
            chk("misalign_sticky", 32'(s_mis), 32'(vt[i].exp_mis));
        end

        // redirect coinciding with a response and a pop
        do_reset();
        mem_lat = 1;
        run(1'b1);
        run(1'b1);
        tick(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0010, 1'b1, 1'b1);
        chk("coincide_valid_before", 32'(s_ivalid), 32'(1));
        run(1'b1);
        chk("coincide_flushed", 32'(s_ivalid), 32'(0));
        wait_valid("coincide_wait_timeout");
        chk("coincide_first_pc", s_ipc, 32'h0000_0050);

        // reset with a full buffer and the sticky flag set
        do_reset();
        mem_lat = 1;
        run(1'b1);
        run(1'b1);
        tick(1'b0, 1'b1, 32'h0000_0200, 32'h0000_0006, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) run(1'b0);
        chk("full_valid", 32'(s_ivalid), 32'(1));
        chk("full_misalign", 32'(s_mis), 32'(1));
        tick(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        run(1'b1);
        chk("post_rst_valid", 32'(s_ivalid), 32'(0));
        chk("post_rst_misalign", 32'(s_mis), 32'(0));
        chk("post_rst_addr", s_reqaddr, RESET_PC);
        chk("post_rst_req_valid", 32'(s_reqv), 32'(1));

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            logic        r, rv;
            logic [31:0] rb, ri;
            r  = ($urandom_range(0, 199) == 0);
            rv = ($urandom_range(0, 15) == 0);
            rb = $urandom;
            ri = $urandom;
            ri[0] = 1'b0;
            mem_lat = $urandom_range(1, 3);
            tick(r, rv, rb, ri, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
